// File: rtl/load_pkg.sv
// Shared types and helpers for the load datapath: FSM states, load-width codes
// and the misalignment rule.
package load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ0 = 2'd1,
        REQ1 = 2'd2,
        WB   = 2'd3
    } load_state_e;

    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    // A load is misaligned when its bytes straddle a word boundary; code 2'b11 behaves as word.
    function automatic logic is_misaligned(input logic [1:0] option, input logic [1:0] offset);
        logic result;
        case (option)
            LOAD_BYTE: result = 1'b0;
            LOAD_HALF: result = (offset == 2'b11);
            default:   result = (offset != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_data_unit_if.sv
// Bundle of the load-request, data-memory and writeback channels of the load unit.
// slave: the load unit itself; master: the surrounding pipeline and memory.
interface load_data_unit_if #(
    parameter int ADDR_W = 32
);
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_option;
    logic              ld_unsigned;
    logic [4:0]        ld_rd;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_data;
    logic [4:0]        wb_rd;
    logic              wb_err;

    modport slave (
        input  ld_valid, ld_addr, ld_option, ld_unsigned, ld_rd,
        input  mem_ack, mem_rdata, wb_ready,
        output ld_ready, mem_req, mem_addr, wb_valid, wb_data, wb_rd, wb_err
    );

    modport master (
        output ld_valid, ld_addr, ld_option, ld_unsigned, ld_rd,
        output mem_ack, mem_rdata, wb_ready,
        input  ld_ready, mem_req, mem_addr, wb_valid, wb_data, wb_rd, wb_err
    );
endinterface

// File: rtl/load_data_unit_extract.sv
// Lane extraction and sign/zero extension of a load from a {hi,lo} word pair.
// Only hi[23:0] can ever reach the result (offset is at most 3 bytes).
module load_extract
    import load_pkg::*;
(
    input  logic [23:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  option_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [31:0] lane_s;

    // Shift the pair right by whole bytes, then trim and extend to the load width.
    always_comb begin
        lane_s   = lo_i;
        result_o = 32'd0;
        case (offset_i)
            2'd0:    lane_s = lo_i;
            2'd1:    lane_s = {hi_i[7:0],  lo_i[31:8]};
            2'd2:    lane_s = {hi_i[15:0], lo_i[31:16]};
            default: lane_s = {hi_i[23:0], lo_i[31:24]};
        endcase
        case (option_i)
            LOAD_BYTE: begin
                if (unsigned_i) begin
                    result_o = {24'd0, lane_s[7:0]};
                end else begin
                    result_o = {{24{lane_s[7]}}, lane_s[7:0]};
                end
            end
            LOAD_HALF: begin
                if (unsigned_i) begin
                    result_o = {16'd0, lane_s[15:0]};
                end else begin
                    result_o = {{16{lane_s[15]}}, lane_s[15:0]};
                end
            end
            default: result_o = lane_s;
        endcase
    end

endmodule

// File: rtl/load_data_unit.sv
// Load datapath stage: word reads over req/ack, lane extraction and writeback handoff.
// Build option LOAD_MISALIGNED_SPLIT_EN: split misaligned loads into two word reads instead of rejecting them.
module load_data_unit
    import load_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic             clk,
    input logic             reset,
    load_data_unit_if.slave bus
);

`ifdef LOAD_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    load_state_e       state_q, state_d;
    logic [1:0]        offset_q, offset_d;
    logic [1:0]        option_q, option_d;
    logic              unsigned_q, unsigned_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       lo_q, lo_d;
    logic              ld_ready_q, ld_ready_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              wb_err_q, wb_err_d;

    logic              misaligned_in_s;
    logic              misaligned_q_s;
    logic              ack_s;
    logic [23:0]       ext_hi_s;
    logic [31:0]       ext_lo_s;
    logic [31:0]       ext_result_s;

    assign misaligned_in_s = is_misaligned(bus.ld_option, bus.ld_addr[1:0]);
    assign misaligned_q_s  = is_misaligned(option_q, offset_q);
    // mem_ack is meaningful only while a request is outstanding.
    assign ack_s           = mem_req_q & bus.mem_ack;

    // The second read supplies the high word; a single read has no high word.
    assign ext_lo_s = (state_q == REQ1) ? lo_q : bus.mem_rdata;
    assign ext_hi_s = (state_q == REQ1) ? bus.mem_rdata[23:0] : 24'd0;

    load_extract u_extract (
        .hi_i       (ext_hi_s),
        .lo_i       (ext_lo_s),
        .offset_i   (offset_q),
        .option_i   (option_q),
        .unsigned_i (unsigned_q),
        .result_o   (ext_result_s)
    );

    // State and output/capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            offset_q   <= 2'd0;
            option_q   <= 2'd0;
            unsigned_q <= 1'b0;
            rd_q       <= 5'd0;
            lo_q       <= 32'd0;
            ld_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            option_q   <= option_d;
            unsigned_q <= unsigned_d;
            rd_q       <= rd_d;
            lo_q       <= lo_d;
            ld_ready_q <= ld_ready_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.ld_valid) begin
                    if (misaligned_in_s && !SPLIT_EN) begin
                        state_d = WB;
                    end else begin
                        state_d = REQ0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ0: begin
                if (ack_s) begin
                    if (misaligned_q_s && SPLIT_EN) begin
                        state_d = REQ1;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    state_d = REQ0;
                end
            end
            REQ1: begin
                if (ack_s) begin
                    state_d = WB;
                end else begin
                    state_d = REQ1;
                end
            end
            WB: begin
                if (bus.wb_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = WB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and capture next values; handshake outputs follow the next state so they stay registered.
    always_comb begin
        offset_d   = offset_q;
        option_d   = option_q;
        unsigned_d = unsigned_q;
        rd_d       = rd_q;
        lo_d       = lo_q;
        mem_addr_d = mem_addr_q;
        wb_data_d  = wb_data_q;
        wb_err_d   = wb_err_q;
        ld_ready_d = (state_d == IDLE);
        mem_req_d  = (state_d == REQ0) || (state_d == REQ1);
        wb_valid_d = (state_d == WB);
        case (state_q)
            IDLE: begin
                if (bus.ld_valid) begin
                    offset_d   = bus.ld_addr[1:0];
                    option_d   = bus.ld_option;
                    unsigned_d = bus.ld_unsigned;
                    rd_d       = bus.ld_rd;
                    mem_addr_d = {bus.ld_addr[ADDR_W-1:2], 2'b00};
                    wb_err_d   = misaligned_in_s && !SPLIT_EN;
                    if (misaligned_in_s && !SPLIT_EN) begin
                        wb_data_d = 32'd0;
                    end else begin
                        wb_data_d = wb_data_q;
                    end
                end else begin
                    wb_err_d = wb_err_q;
                end
            end
            REQ0: begin
                if (ack_s) begin
                    lo_d = bus.mem_rdata;
                    if (state_d == REQ1) begin
                        mem_addr_d = mem_addr_q + ADDR_W'(4);
                    end else begin
                        wb_data_d = ext_result_s;
                    end
                end else begin
                    lo_d = lo_q;
                end
            end
            REQ1: begin
                if (ack_s) begin
                    wb_data_d = ext_result_s;
                end else begin
                    wb_data_d = wb_data_q;
                end
            end
            WB:      wb_data_d = wb_data_q;
            default: wb_data_d = wb_data_q;
        endcase
    end

    assign bus.ld_ready = ld_ready_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_rd    = rd_q;
    assign bus.wb_err   = wb_err_q;

endmodule

// File: tb/tb_load_data_unit.sv
// Directed bench for load_data_unit: small memory responder with programmable ack delay,
// hand-computed expected results, immediate assertions at each comparison.
module tb_load_data_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_data_unit_if #(.ADDR_W(32)) bus ();

    load_data_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    logic        ack_force = 1'b0;
    int          wcnt = 0;
    int          nreq = 0;
    logic [31:0] req_log [0:63];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h8899_AABB;
            32'h0000_0104: return 32'h1122_3344;
            32'hFFFF_FFFC: return 32'hA1B2_C3D4;
            32'h0000_0000: return 32'h5566_7788;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign bus.mem_rdata = mem_read(bus.mem_addr);
    assign bus.mem_ack   = ack_force | (ack_en & bus.mem_req & (wcnt == ack_delay));

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.mem_req && bus.mem_ack) begin
            req_log[nreq[5:0]] <= bus.mem_addr;
            nreq <= nreq + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] opt, input logic uns, input logic [4:0] rd);
        check("accept_ready", 32'(bus.ld_ready), 32'd1);
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = a;
        bus.ld_option   = opt;
        bus.ld_unsigned = uns;
        bus.ld_rd       = rd;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic wait_wb(input string tag, input int exp_lat);
        int lat = 1;
        while (bus.wb_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    // Full load with wb_ready high: latency, result, tag, error, read count, then handshake.
    task automatic load_check(input string tag, input logic [31:0] a, input logic [1:0] opt,
                              input logic uns, input logic [4:0] rd, input int exp_lat,
                              input logic [31:0] exp_data, input logic exp_err, input int exp_reqs);
        int base = nreq;
        issue(a, opt, uns, rd);
        wait_wb(tag, exp_lat);
        check({tag, "_data"}, bus.wb_data, exp_data);
        check({tag, "_rd"}, 32'(bus.wb_rd), 32'(rd));
        check({tag, "_err"}, 32'(bus.wb_err), 32'(exp_err));
        check({tag, "_nreq"}, 32'(nreq - base), 32'(exp_reqs));
        tick();
        check({tag, "_done"}, 32'(bus.wb_valid), 32'd0);
    endtask

    initial begin
        int base;
        reset           = 1'b1;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = 32'd0;
        bus.ld_option   = 2'b00;
        bus.ld_unsigned = 1'b0;
        bus.ld_rd       = 5'd0;
        bus.wb_ready    = 1'b1;
        tick();
        tick();
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        check("rst_wb_err", 32'(bus.wb_err), 32'd0);
        reset = 1'b0;
        tick();

        // Byte signed at 0x101: single read at 0x100, result at cycle 2.
        base = nreq;
        issue(32'h101, 2'b00, 1'b0, 5'd5);
        check("b_req", 32'(bus.mem_req), 32'd1);
        check("b_addr", bus.mem_addr, 32'h100);
        wait_wb("b", 2);
        check("b_data", bus.wb_data, 32'hFFFF_FFAA);
        check("b_rd", 32'(bus.wb_rd), 32'd5);
        check("b_nreq", 32'(nreq - base), 32'd1);
        tick();
        check("b_idle", 32'(bus.ld_ready), 32'd1);

        // Half unsigned at 0x102 with two wait cycles: address held, result at cycle 4.
        ack_delay = 2;
        issue(32'h102, 2'b01, 1'b1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            check("h_req_hold", 32'(bus.mem_req), 32'd1);
            check("h_addr_hold", bus.mem_addr, 32'h100);
            tick();
        end
        check("h_valid_c4", 32'(bus.wb_valid), 32'd1);
        check("h_data", bus.wb_data, 32'h0000_8899);
        tick();
        ack_delay = 0;

        load_check("hs", 32'h100, 2'b01, 1'b0, 5'd4, 2, 32'hFFFF_AABB, 1'b0, 1);
        load_check("bu", 32'h103, 2'b00, 1'b1, 5'd6, 2, 32'h0000_0088, 1'b0, 1);
        load_check("w", 32'h104, 2'b10, 1'b0, 5'd8, 2, 32'h1122_3344, 1'b0, 1);

`ifdef LOAD_MISALIGNED_SPLIT_EN
        base = nreq;
        load_check("wm", 32'h103, 2'b10, 1'b0, 5'd10, 3, 32'h2233_4488, 1'b0, 2);
        check("wm_a0", req_log[base[5:0]], 32'h100);
        check("wm_a1", req_log[6'(base + 1)], 32'h104);
        base = nreq;
        load_check("wrap", 32'hFFFF_FFFE, 2'b11, 1'b0, 5'd11, 3, 32'h7788_A1B2, 1'b0, 2);
        check("wrap_a0", req_log[base[5:0]], 32'hFFFF_FFFC);
        check("wrap_a1", req_log[6'(base + 1)], 32'h0000_0000);
`else
        load_check("wm", 32'h103, 2'b10, 1'b0, 5'd10, 1, 32'h0, 1'b1, 0);
        load_check("wrap", 32'hFFFF_FFFE, 2'b11, 1'b0, 5'd11, 1, 32'h0, 1'b1, 0);
        load_check("hm", 32'h103, 2'b01, 1'b1, 5'd12, 1, 32'h0, 1'b1, 0);
`endif

        // Writeback stall: result held, new request ignored until the cycle after the handshake.
        bus.wb_ready = 1'b0;
        issue(32'h103, 2'b00, 1'b1, 5'd9);
        wait_wb("st", 2);
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = 32'h104;
        bus.ld_option   = 2'b10;
        bus.ld_unsigned = 1'b0;
        bus.ld_rd       = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_valid", 32'(bus.wb_valid), 32'd1);
            check("st_data", bus.wb_data, 32'h0000_0088);
            check("st_rd", 32'(bus.wb_rd), 32'd9);
            check("st_ready", 32'(bus.ld_ready), 32'd0);
            check("st_noreq", 32'(bus.mem_req), 32'd0);
        end
        bus.wb_ready = 1'b1;
        tick();
        check("st_hs_valid", 32'(bus.wb_valid), 32'd0);
        check("st_hs_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        bus.ld_valid = 1'b0;
        check("st_next_req", 32'(bus.mem_req), 32'd1);
        check("st_next_addr", bus.mem_addr, 32'h104);
        wait_wb("st_next", 2);
        check("st_next_data", bus.wb_data, 32'h1122_3344);
        check("st_next_rd", 32'(bus.wb_rd), 32'd3);
        tick();

        // Reset while REQ0 waits for an ack; a late ack must not revive the load.
        ack_en = 1'b0;
        base = nreq;
        issue(32'h100, 2'b01, 1'b0, 5'd7);
        check("r_req", 32'(bus.mem_req), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_mem_req", 32'(bus.mem_req), 32'd0);
        check("r_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("r_wb_valid", 32'(bus.wb_valid), 32'd0);
        ack_force = 1'b1;
        ack_en    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r_late_valid", 32'(bus.wb_valid), 32'd0);
            check("r_late_req", 32'(bus.mem_req), 32'd0);
        end
        ack_force = 1'b0;
        check("r_nreq", 32'(nreq - base), 32'd0);
        tick();

        load_check("post", 32'h100, 2'b00, 1'b0, 5'd1, 2, 32'hFFFF_FFBB, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_data_unit.md
# load_data_unit

Load datapath stage directly downstream of load-width decode: consumes the 2-bit load option (byte/half/word) plus address and unsigned flag, performs the data-memory read over a req/ack handshake, extracts the addressed lanes, sign- or zero-extends, and hands a 32-bit result to register writeback. Misaligned loads are either split into two word reads or rejected, depending on build configuration.

## Interface
- ADDR_W, 32, address width (data width fixed at 32)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ld_valid  in  1  load request present
- ld_ready  out  1  unit can accept a request
- ld_addr  in  ADDR_W  byte address
- ld_option  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ld_unsigned  in  1  1 = zero-extend (funct3[14])
- ld_rd  in  5  destination register tag
- mem_req  out  1  word read request, held until ack
- mem_addr  out  ADDR_W  word-aligned address, [1:0] always 0
- mem_ack  in  1  read data valid; sampled only while mem_req=1
- mem_rdata  in  32  read word, little-endian
- wb_valid  out  1  result present
- wb_ready  in  1  writeback accepts result
- wb_data  out  32  extended load result
- wb_rd  out  5  latched ld_rd
- wb_err  out  1  misaligned-load error (only without split feature)

## Operation
- States IDLE, REQ0, REQ1, WB.
- IDLE: ld_ready=1. ld_valid latches addr/option/unsigned/rd. Misaligned = half with addr[1:0]=3, or word with addr[1:0]≠0. Aligned or split-enabled → REQ0; misaligned without split → WB with wb_err=1, wb_data=0, no memory access.
- REQ0: mem_req=1, mem_addr={addr[ADDR_W-1:2],2'b00}. On mem_ack capture lo word; misaligned → REQ1, else → WB.
- REQ1: mem_req=1, mem_addr = REQ0 word address + 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000). On mem_ack capture hi word → WB.
- WB: wb_valid=1, wb_data/wb_rd/wb_err stable until wb_ready; on wb_valid&wb_ready → IDLE.
- Extraction: {hi,lo} >> (8·addr[1:0]); low 8/16/32 bits per option; bit 7/15 replicated unless ld_unsigned. hi = 0 when unused.
- ld_ready=0 outside IDLE; ld_valid then ignored (no queueing).

## Timing
- Reset values: state IDLE, ld_ready=1, mem_req=0, mem_addr=0, wb_valid=0, wb_data=0, wb_rd=0, wb_err=0.
- Accept edge = cycle 0. Zero-wait memory (ack same cycle as req): aligned wb_valid at cycle 2, split at cycle 3, rejected misaligned at cycle 1.
- Each wait cycle with mem_req=1, mem_ack=0 adds one cycle; mem_addr stable while mem_req=1.
- Back-to-back: next request accepted the cycle after wb handshake (minimum period 3 cycles aligned).
- Reset mid-operation: next cycle IDLE, mem_req=0, wb_valid=0; in-flight result discarded; a late mem_ack after reset is ignored.

## Configuration
- LOAD_MISALIGNED_SPLIT_EN defined: misaligned loads take REQ0+REQ1; wb_err tied 0.
- Undefined: REQ1 unreachable (may be optimised out); misaligned loads return wb_err=1, wb_data=0 without touching memory.

## Structure
- Package load_pkg: state enum (IDLE/REQ0/REQ1/WB), option constants LOAD_BYTE=2'b00, LOAD_HALF=2'b01, LOAD_WORD=2'b10, misalignment-check function.
- Sub-module load_extract: combinational {hi,lo}, offset, option, unsigned → 32-bit result. FSM and capture registers in load_data_unit.

## Test plan
Memory: 0x100 = 0x8899AABB, 0x104 = 0x11223344, zero-wait unless stated.
- Byte signed, addr 0x101 → one mem_req at 0x100, wb_data 0xFFFFFFAA at cycle 2, wb_rd = ld_rd.
- Half unsigned, addr 0x102, mem_ack delayed 2 cycles → wb_data 0x00008899 at cycle 4, mem_addr 0x100 stable throughout.
- Word addr 0x103: with macro → reqs 0x100 then 0x104, wb_data 0x22334488 at cycle 3; without → no mem_req, wb_err=1, wb_data 0 at cycle 1.
- Word addr 0xFFFFFFFE with macro → second mem_addr 0x00000000.
- wb_ready low 3 cycles in WB → wb_data stable, ld_ready=0, concurrent ld_valid not accepted; accepted the cycle after handshake.
- Reset asserted in REQ0 with mem_ack low → next cycle mem_req=0, ld_ready=1, no wb_valid ever for that request.
